// File: rtl/toy_mem_banked_tcm.sv
// toy_mem_banked_tcm
// Multi-port, multi-bank tightly-coupled memory. NUM_PORTS requesters share
// NUM_BANKS word-interleaved banks. Each bank has its own round-robin arbiter.
// Every accepted request returns exactly one response RD_LATENCY cycles later.
//
// Ports (per-port vectors flattened, port p occupies slice p):
//   clk, rst          : clock, synchronous active-high reset
//   req_vld/req_rdy   : request handshake
//   req_addr          : byte address
//   req_wr_en         : 1 = write, 0 = read
//   req_wr_data       : write data
//   req_wr_byte_en    : write byte strobes
//   req_sideband      : opaque tag echoed on the response
//   rsp_vld           : one-cycle response strobe, no backpressure
//   rsp_is_wr         : response belongs to a write
//   rsp_rd_data       : read data (zero for writes)
//   rsp_sideband      : sideband of the originating request
//
// Handshake: a request transfers on a cycle where req_vld[p] && req_rdy[p].
// req_rdy is combinational from req_vld/req_addr, so a requester must never
// make req_vld depend on req_rdy. An unaccepted request must be held stable;
// the block keeps no state for it. Responses cannot be stalled.
module toy_mem_banked_tcm #(
  parameter int NUM_PORTS  = 2,
  parameter int NUM_BANKS  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int BANK_DEPTH = 1024,
  parameter int SB_WIDTH   = 10,
  parameter int RD_LATENCY = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            req_vld,
  output logic [NUM_PORTS-1:0]            req_rdy,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS-1:0]            req_wr_en,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wr_data,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] req_wr_byte_en,
  input  logic [NUM_PORTS*SB_WIDTH-1:0]   req_sideband,
  output logic [NUM_PORTS-1:0]            rsp_vld,
  output logic [NUM_PORTS-1:0]            rsp_is_wr,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] rsp_rd_data,
  output logic [NUM_PORTS*SB_WIDTH-1:0]   rsp_sideband
);
  localparam int BE_W = DATA_WIDTH / 8;
  localparam int B_SH = $clog2(BE_W);
  localparam int K_SH = $clog2(NUM_BANKS);
  localparam int BW   = (NUM_BANKS > 1) ? K_SH : 1;
  localparam int RW   = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
  localparam int PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  // Low (byte-in-word) and high (above the row) address bits are ignored.
  logic w_unused_addr;
  assign w_unused_addr = ^req_addr;

  // Address decode per port: word = addr >> B, bank = low K word bits,
  // row = remaining word bits modulo BANK_DEPTH (rows wrap).
  logic [BW-1:0]         w_bank    [NUM_PORTS];
  logic [RW-1:0]         w_row     [NUM_PORTS];
  logic [DATA_WIDTH-1:0] w_rd_data [NUM_PORTS];
  logic [DATA_WIDTH-1:0] r_mem     [NUM_BANKS][BANK_DEPTH];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_dec
    logic [ADDR_WIDTH-1:0] w_word;
    assign w_word       = req_addr[p*ADDR_WIDTH +: ADDR_WIDTH] >> B_SH;
    assign w_bank[p]    = BW'(w_word & ADDR_WIDTH'(NUM_BANKS - 1));
    assign w_row[p]     = RW'((w_word >> K_SH) & ADDR_WIDTH'(BANK_DEPTH - 1));
    // Sampled at the accept edge; a same-edge write cannot hit this bank.
    assign w_rd_data[p] = r_mem[w_bank[p]][w_row[p]];
  end

  // Per-bank round-robin arbitration.
  logic [PW-1:0]        r_rr       [NUM_BANKS];
  logic [NUM_BANKS-1:0] w_bank_hit;
  logic [PW-1:0]        w_bank_gnt [NUM_BANKS];
  logic [NUM_PORTS-1:0] w_acc;
  logic [PW-1:0]        w_cand;

  always_comb begin
    w_bank_hit = '0;
    w_acc      = '0;
    w_cand     = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_bank_gnt[b] = '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
        w_cand = PW'((int'(r_rr[b]) + o) % NUM_PORTS);
        if (!rst && !w_bank_hit[b] && req_vld[w_cand] && (w_bank[w_cand] == BW'(b))) begin
          w_bank_hit[b]  = 1'b1;
          w_bank_gnt[b]  = w_cand;
          w_acc[w_cand]  = 1'b1;
        end
      end
    end
  end

  assign req_rdy = w_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANKS; b++) r_rr[b] <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (w_bank_hit[b]) r_rr[b] <= PW'((int'(w_bank_gnt[b]) + 1) % NUM_PORTS);
      end
    end
  end

  // Route the granted port's write fields to each bank.
  logic                  w_bk_we    [NUM_BANKS];
  logic [RW-1:0]         w_bk_row   [NUM_BANKS];
  logic [DATA_WIDTH-1:0] w_bk_wdata [NUM_BANKS];
  logic [BE_W-1:0]       w_bk_be    [NUM_BANKS];

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_bk_we[b]    = 1'b0;
      w_bk_row[b]   = '0;
      w_bk_wdata[b] = '0;
      w_bk_be[b]    = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_bank_hit[b] && (w_bank_gnt[b] == PW'(p))) begin
          w_bk_we[b]    = req_wr_en[p];
          w_bk_row[b]   = w_row[p];
          w_bk_wdata[b] = req_wr_data[p*DATA_WIDTH +: DATA_WIDTH];
          w_bk_be[b]    = req_wr_byte_en[p*BE_W +: BE_W];
        end
      end
    end
  end

  // Array contents are intentionally not reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (w_bk_we[b]) begin
        for (int i = 0; i < BE_W; i++) begin
          if (w_bk_be[b][i]) r_mem[b][w_bk_row[b]][i*8 +: 8] <= w_bk_wdata[b][i*8 +: 8];
        end
      end
    end
  end

  // Response pipeline: stage 0 loads at the accept edge, the last stage
  // drives the outputs. Payload fields only move with a valid entry, so the
  // outputs hold their last value while rsp_vld is low.
  logic [NUM_PORTS-1:0]            r_p_vld  [RD_LATENCY];
  logic [NUM_PORTS-1:0]            r_p_wr   [RD_LATENCY];
  logic [NUM_PORTS*DATA_WIDTH-1:0] r_p_data [RD_LATENCY];
  logic [NUM_PORTS*SB_WIDTH-1:0]   r_p_sb   [RD_LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < RD_LATENCY; s++) begin
        r_p_vld[s]  <= '0;
        r_p_wr[s]   <= '0;
        r_p_data[s] <= '0;
        r_p_sb[s]   <= '0;
      end
    end else begin
      r_p_vld[0] <= w_acc;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_acc[p]) begin
          r_p_wr[0][p]                         <= req_wr_en[p];
          r_p_data[0][p*DATA_WIDTH +: DATA_WIDTH] <= req_wr_en[p] ? '0 : w_rd_data[p];
          r_p_sb[0][p*SB_WIDTH +: SB_WIDTH]    <= req_sideband[p*SB_WIDTH +: SB_WIDTH];
        end
      end
      for (int s = 1; s < RD_LATENCY; s++) begin
        r_p_vld[s] <= r_p_vld[s-1];
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (r_p_vld[s-1][p]) begin
            r_p_wr[s][p]                            <= r_p_wr[s-1][p];
            r_p_data[s][p*DATA_WIDTH +: DATA_WIDTH] <= r_p_data[s-1][p*DATA_WIDTH +: DATA_WIDTH];
            r_p_sb[s][p*SB_WIDTH +: SB_WIDTH]       <= r_p_sb[s-1][p*SB_WIDTH +: SB_WIDTH];
          end
        end
      end
    end
  end

  assign rsp_vld      = r_p_vld[RD_LATENCY-1];
  assign rsp_is_wr    = r_p_wr[RD_LATENCY-1];
  assign rsp_rd_data  = r_p_data[RD_LATENCY-1];
  assign rsp_sideband = r_p_sb[RD_LATENCY-1];

endmodule

// File: tb/tb_toy_mem_banked_tcm.sv
// Bench for toy_mem_banked_tcm: directed literal cases plus randomized traffic
// compared every cycle against a behavioural model (flat word memory,
// per-bank round-robin pointers, per-port expected-response queues).
module tb_toy_mem_banked_tcm;
  localparam int NP = 2, NB = 4, AW = 32, DW = 64, DEPTH = 1024, SBW = 10, L = 2;
  localparam int BEW = DW / 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NP-1:0]     req_vld = '0;
  logic [NP-1:0]     req_wr_en = '0;
  logic [NP*AW-1:0]  req_addr = '0;
  logic [NP*DW-1:0]  req_wr_data = '0;
  logic [NP*BEW-1:0] req_wr_byte_en = '0;
  logic [NP*SBW-1:0] req_sideband = '0;
  logic [NP-1:0]     req_rdy, rsp_vld, rsp_is_wr;
  logic [NP*DW-1:0]  rsp_rd_data;
  logic [NP*SBW-1:0] rsp_sideband;

  toy_mem_banked_tcm #(
    .NUM_PORTS(NP), .NUM_BANKS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .BANK_DEPTH(DEPTH), .SB_WIDTH(SBW), .RD_LATENCY(L)
  ) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_addr(req_addr),
    .req_wr_en(req_wr_en), .req_wr_data(req_wr_data),
    .req_wr_byte_en(req_wr_byte_en), .req_sideband(req_sideband),
    .rsp_vld(rsp_vld), .rsp_is_wr(rsp_is_wr),
    .rsp_rd_data(rsp_rd_data), .rsp_sideband(rsp_sideband)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model / scoreboard ----------------
  typedef struct packed {
    logic [31:0]    due;
    logic           is_wr;
    logic [DW-1:0]  data;
    logic [SBW-1:0] sb;
  } rsp_t;

  rsp_t          exp_q [NP][$];
  logic [DW-1:0] m_mem [NB*DEPTH];
  int            m_rr  [NB];
  logic [DW-1:0] last_data [NP];
  logic [SBW-1:0] last_sb [NP];
  logic          last_wr [NP];
  int            cyc = 0;

  function automatic int word_idx(input logic [31:0] a);
    return int'((a >> 3) % (NB * DEPTH));
  endfunction

  function automatic int bank_of(input logic [31:0] a);
    return int'((a >> 3) % NB);
  endfunction

  initial begin
    for (int b = 0; b < NB; b++) m_rr[b] = 0;
    for (int p = 0; p < NP; p++) begin
      last_data[p] = '0; last_sb[p] = '0; last_wr[p] = 1'b0;
    end
  end

  always @(negedge clk) begin : compare
    logic [NP-1:0] eg;
    rsp_t e;
    for (int p = 0; p < NP; p++) begin
      if (exp_q[p].size() > 0 && exp_q[p][0].due == cyc) begin
        e = exp_q[p].pop_front();
        chk("rsp_vld", DW'(rsp_vld[p]), 1);
        chk("rsp_is_wr", DW'(rsp_is_wr[p]), DW'(e.is_wr));
        chk("rsp_data", rsp_rd_data[p*DW +: DW], e.data);
        chk("rsp_sb", DW'(rsp_sideband[p*SBW +: SBW]), DW'(e.sb));
        last_data[p] = e.data; last_sb[p] = e.sb; last_wr[p] = e.is_wr;
      end else begin
        chk("rsp_idle", DW'(rsp_vld[p]), 0);
        chk("rsp_hold_data", rsp_rd_data[p*DW +: DW], last_data[p]);
        chk("rsp_hold_sb", DW'(rsp_sideband[p*SBW +: SBW]), DW'(last_sb[p]));
        chk("rsp_hold_wr", DW'(rsp_is_wr[p]), DW'(last_wr[p]));
      end
    end
    eg = '0;
    if (!rst) begin
      for (int b = 0; b < NB; b++) begin
        for (int o = 0; o < NP; o++) begin
          int q;
          q = (m_rr[b] + o) % NP;
          if (req_vld[q] && bank_of(req_addr[q*AW +: AW]) == b) begin
            eg[q] = 1'b1;
            m_rr[b] = (q + 1) % NP;
            break;
          end
        end
      end
    end
    chk("req_rdy", DW'(req_rdy), DW'(eg));
    for (int q = 0; q < NP; q++) begin
      if (eg[q]) begin
        int idx;
        idx = word_idx(req_addr[q*AW +: AW]);
        e.due = 32'(cyc + L);
        e.sb  = req_sideband[q*SBW +: SBW];
        e.is_wr = req_wr_en[q];
        if (req_wr_en[q]) begin
          e.data = '0;
          for (int i = 0; i < BEW; i++)
            if (req_wr_byte_en[q*BEW + i]) m_mem[idx][i*8 +: 8] = req_wr_data[q*DW + i*8 +: 8];
        end else begin
          e.data = m_mem[idx];
        end
        exp_q[q].push_back(e);
      end
    end
    if (rst) begin
      for (int p = 0; p < NP; p++) begin
        exp_q[p].delete();
        last_data[p] = '0; last_sb[p] = '0; last_wr[p] = 1'b0;
      end
      for (int b = 0; b < NB; b++) m_rr[b] = 0;
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int p, input logic v, input logic [31:0] a, input logic w,
                         input logic [DW-1:0] d, input logic [BEW-1:0] be, input logic [SBW-1:0] sb);
    req_vld[p] = v;
    req_addr[p*AW +: AW] = a;
    req_wr_en[p] = w;
    req_wr_data[p*DW +: DW] = d;
    req_wr_byte_en[p*BEW +: BEW] = be;
    req_sideband[p*SBW +: SBW] = sb;
  endtask

  // Present one request on port p until accepted; returns one cycle after the accept.
  task automatic drive_one(input int p, input logic [31:0] a, input logic w,
                           input logic [DW-1:0] d, input logic [BEW-1:0] be, input logic [SBW-1:0] sb);
    bit ok = 1'b0;
    set_req(p, 1'b1, a, w, d, be, sb);
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (req_rdy[p]) ok = 1'b1;
      @(posedge clk); #1;
    end
    req_vld[p] = 1'b0;
    chk("accept_timeout", DW'(ok), 1);
  endtask

  // Called right after drive_one: the response must be present exactly L cycles after the accept.
  task automatic expect_rsp(input int p, input logic w, input logic [DW-1:0] d, input logic [SBW-1:0] sb);
    repeat (L - 1) begin @(posedge clk); #1; end
    chk("lit_vld", DW'(rsp_vld[p]), 1);
    chk("lit_is_wr", DW'(rsp_is_wr[p]), DW'(w));
    chk("lit_data", rsp_rd_data[p*DW +: DW], d);
    chk("lit_sb", DW'(rsp_sideband[p*SBW +: SBW]), DW'(sb));
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [NP-1:0] pend;
    logic [31:0] a;
    rst = 1'b1;
    set_req(0, 1'b1, 32'h0, 1'b0, '0, '0, '0);
    set_req(1, 1'b1, 32'h20, 1'b0, '0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_vld", DW'(rsp_vld), 0);
    chk("reset_rsp_data", rsp_rd_data[DW-1:0], 0);
    chk("reset_rsp_sb", DW'(rsp_sideband), 0);
    chk("reset_rsp_is_wr", DW'(rsp_is_wr), 0);
    chk("reset_req_rdy", DW'(req_rdy), 0);
    rst = 1'b0;
    req_vld = '0;

    // Preload the 32 words used by the rest of the run.
    for (int w = 0; w < 32; w++)
      drive_one(w % NP, 32'(w * 8), 1'b1, {$urandom, $urandom}, 8'hFF, 10'($urandom_range(0, 1023)));

    // Single write then read.
    drive_one(0, 32'h40, 1'b1, 64'h1122334455667788, 8'hFF, 10'h3A);
    expect_rsp(0, 1'b1, 64'h0, 10'h3A);
    drive_one(0, 32'h40, 1'b0, 64'h0, 8'h00, 10'h15);
    expect_rsp(0, 1'b0, 64'h1122334455667788, 10'h15);

    // Byte strobes.
    drive_one(1, 32'h80, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 10'h001);
    drive_one(1, 32'h80, 1'b1, 64'h0, 8'h0F, 10'h002);
    drive_one(1, 32'h80, 1'b0, 64'h0, 8'h00, 10'h003);
    expect_rsp(1, 1'b0, 64'hFFFF_FFFF_0000_0000, 10'h003);

    // Row wrap: 0x8000 aliases word 0.
    drive_one(0, 32'h8000, 1'b1, 64'hA5, 8'hFF, 10'h0AA);
    drive_one(0, 32'h0, 1'b0, 64'h0, 8'h00, 10'h0AB);
    expect_rsp(0, 1'b0, 64'hA5, 10'h0AB);

    // Parallel banks.
    set_req(0, 1'b1, 32'h00, 1'b0, '0, '0, 10'h101);
    set_req(1, 1'b1, 32'h08, 1'b0, '0, '0, 10'h102);
    @(negedge clk);
    chk("par_rdy", DW'(req_rdy), 2'b11);
    @(posedge clk); #1;
    req_vld = '0;
    repeat (L - 1) begin @(posedge clk); #1; end
    chk("par_rsp", DW'(rsp_vld), 2'b11);

    // Reset mid-flight, then conflict on bank 0 right after reset.
    set_req(0, 1'b1, 32'h0, 1'b0, '0, '0, 10'h2C);
    @(negedge clk);
    chk("mf_accept", DW'(req_rdy[0]), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    set_req(0, 1'b1, 32'h00, 1'b0, '0, '0, 10'h011);
    set_req(1, 1'b1, 32'h20, 1'b0, '0, '0, 10'h022);
    @(negedge clk);
    chk("rdy_in_reset", DW'(req_rdy), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) chk("mf_no_rsp", DW'(rsp_vld[0]), 0);
      chk("conflict_gnt", DW'(req_rdy), (k % 2 == 0) ? 64'h1 : 64'h2);
      @(posedge clk); #1;
    end
    req_vld = '0;

    // Randomized traffic; unaccepted requests are held stable.
    pend = '0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int p = 0; p < NP; p++) begin
        if (!pend[p]) begin
          if ($urandom_range(0, 3) != 0) begin
            a = ($urandom & 32'hFFFF_8000) | ($urandom & 32'h0000_00FF);
            set_req(p, 1'b1, a, 1'($urandom_range(0, 1)), {$urandom, $urandom},
                    8'($urandom_range(0, 255)), 10'($urandom_range(0, 1023)));
          end else begin
            req_vld[p] = 1'b0;
          end
        end
      end
      @(negedge clk);
      pend = req_vld & ~req_rdy;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    req_vld = '0;
    repeat (L + 3) @(posedge clk);
    #1;
    chk("drain", 64'(exp_q[0].size() + exp_q[1].size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
